// File: rtl/vex_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vex_ram_arbiter
// Purpose  : Shares a single-port sync RAM between the VexRiscv ibus and dbus.
//            Optional macro VEX_ARB_DBUS_PRIORITY_EN selects fixed dbus priority.
// Revision : 1.0
// ============================================================================
module vex_ram_arbiter #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    RAM_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ibus_cmd_valid,
  output logic                      ibus_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     ibus_cmd_addr,
  output logic                      ibus_rsp_valid,
  output logic [31:0]               ibus_rsp_data,
  output logic                      ibus_rsp_error,
  input  logic                      dbus_cmd_valid,
  output logic                      dbus_cmd_ready,
  input  logic                      dbus_cmd_wr,
  input  logic [ADDR_WIDTH-1:0]     dbus_cmd_addr,
  input  logic [31:0]               dbus_cmd_data,
  input  logic [3:0]                dbus_cmd_mask,
  output logic                      dbus_rsp_valid,
  output logic [31:0]               dbus_rsp_data,
  output logic                      dbus_rsp_error,
  output logic                      ram_en,
  output logic [3:0]                ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]               ram_wdata,
  input  logic [31:0]               ram_rdata
);

  localparam logic [ADDR_WIDTH:0] RAM_BYTES = (ADDR_WIDTH+1)'(1) << (RAM_ADDR_WIDTH + 2);
  localparam logic SRC_IBUS = 1'b0;
  localparam logic SRC_DBUS = 1'b1;

  logic                  grant_i;
  logic                  grant_d;
  logic                  accept;
  logic                  is_write;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  pend_valid;
  logic                  pend_src;
  logic                  pend_err;

`ifdef VEX_ARB_DBUS_PRIORITY_EN
  assign grant_i = !reset && ibus_cmd_valid && !dbus_cmd_valid;
`else
  logic last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= SRC_DBUS;
    end else if (accept) begin
      last_grant <= grant_d ? SRC_DBUS : SRC_IBUS;
    end
  end

  // ibus wins a contest whenever dbus was the most recent winner.
  assign grant_i = !reset && ibus_cmd_valid && (!dbus_cmd_valid || last_grant == SRC_DBUS);
`endif

  assign grant_d  = !reset && dbus_cmd_valid && !grant_i;
  assign accept   = grant_i || grant_d;
  assign is_write = grant_d && dbus_cmd_wr;

  assign ibus_cmd_ready = grant_i;
  assign dbus_cmd_ready = grant_d;

  assign sel_addr = grant_d ? dbus_cmd_addr : ibus_cmd_addr;
  assign offset   = sel_addr - BASE_ADDR;
  // Offset is compared unsigned, so the window test cannot wrap at the top of memory.
  assign in_range = (sel_addr >= BASE_ADDR) && ({1'b0, offset} < RAM_BYTES);

  assign ram_addr  = offset[RAM_ADDR_WIDTH+1:2];
  assign ram_wdata = dbus_cmd_data;

  always_comb begin
    ram_en = 1'b0;
    ram_we = 4'b0000;
    if (accept && in_range) begin
      ram_en = 1'b1;
      if (is_write) begin
        ram_we = dbus_cmd_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_src   <= SRC_IBUS;
      pend_err   <= 1'b0;
    end else begin
      pend_valid <= accept && !is_write;
      pend_src   <= grant_d ? SRC_DBUS : SRC_IBUS;
      pend_err   <= !in_range;
    end
  end

  // Responses are masked while reset is high so a read accepted just before reset is lost.
  always_comb begin
    ibus_rsp_valid = !reset && pend_valid && (pend_src == SRC_IBUS);
    dbus_rsp_valid = !reset && pend_valid && (pend_src == SRC_DBUS);
    ibus_rsp_error = ibus_rsp_valid && pend_err;
    dbus_rsp_error = dbus_rsp_valid && pend_err;
    ibus_rsp_data  = (ibus_rsp_valid && !pend_err) ? ram_rdata : 32'h0;
    dbus_rsp_data  = (dbus_rsp_valid && !pend_err) ? ram_rdata : 32'h0;
  end

endmodule
`default_nettype wire

// File: tb/tb_vex_ram_arbiter.sv
`default_nettype none
// Self-checking bench for vex_ram_arbiter: bench RAM, transaction-level model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_vex_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ibus_cmd_valid, ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_error;
  logic [31:0] ibus_cmd_addr, ibus_rsp_data;
  logic        dbus_cmd_valid, dbus_cmd_ready, dbus_cmd_wr, dbus_rsp_valid, dbus_rsp_error;
  logic [31:0] dbus_cmd_addr, dbus_cmd_data, dbus_rsp_data;
  logic [3:0]  dbus_cmd_mask;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vex_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready), .ibus_cmd_addr(ibus_cmd_addr),
    .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_data(ibus_rsp_data), .ibus_rsp_error(ibus_rsp_error),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready), .dbus_cmd_wr(dbus_cmd_wr),
    .dbus_cmd_addr(dbus_cmd_addr), .dbus_cmd_data(dbus_cmd_data), .dbus_cmd_mask(dbus_cmd_mask),
    .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_data(dbus_rsp_data), .dbus_rsp_error(dbus_rsp_error),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bench RAM: single-port, synchronous read, byte-masked write.
  logic [31:0] mem    [0:4095];
  logic [31:0] shadow [0:4095];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  function automatic logic in_win(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a < 32'h8000_4000);
  endfunction

  function automatic logic [11:0] word_of(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'h8000_0000) >> 2;
    return w[11:0];
  endfunction

  // Model state: who won last, and the read awaiting its response.
  logic        m_last_d = 1'b1;
  logic        mp_valid = 1'b0;
  logic        mp_src   = 1'b0;
  logic        mp_err   = 1'b0;
  logic [31:0] mp_data  = 32'h0;

  always @(negedge clk) begin
    logic ei, ed, ew, ok, rvi, rvd;
    logic [31:0] a;
    if (reset) begin
      ei = 1'b0; ed = 1'b0;
    end else if (ibus_cmd_valid && dbus_cmd_valid) begin
`ifdef VEX_ARB_DBUS_PRIORITY_EN
      ed = 1'b1;
`else
      ed = !m_last_d;
`endif
      ei = !ed;
    end else begin
      ei = ibus_cmd_valid; ed = dbus_cmd_valid;
    end
    a  = ed ? dbus_cmd_addr : ibus_cmd_addr;
    ew = ed && dbus_cmd_wr;
    ok = (ei || ed) && in_win(a);

    check("m_ibus_ready", 32'(ibus_cmd_ready), 32'(ei));
    check("m_dbus_ready", 32'(dbus_cmd_ready), 32'(ed));
    check("m_ram_en", 32'(ram_en), 32'(ok));
    check("m_ram_we", 32'(ram_we), (ok && ew) ? 32'(dbus_cmd_mask) : 32'h0);
    if (ok) check("m_ram_addr", 32'(ram_addr), 32'(word_of(a)));
    if (ok && ew) check("m_ram_wdata", ram_wdata, dbus_cmd_data);

    rvi = !reset && mp_valid && !mp_src;
    rvd = !reset && mp_valid && mp_src;
    check("m_ibus_rsp_valid", 32'(ibus_rsp_valid), 32'(rvi));
    check("m_dbus_rsp_valid", 32'(dbus_rsp_valid), 32'(rvd));
    if (rvi || reset) begin
      check("m_ibus_rsp_data", ibus_rsp_data, (rvi && !mp_err) ? mp_data : 32'h0);
      check("m_ibus_rsp_error", 32'(ibus_rsp_error), 32'(rvi && mp_err));
    end
    if (rvd || reset) begin
      check("m_dbus_rsp_data", dbus_rsp_data, (rvd && !mp_err) ? mp_data : 32'h0);
      check("m_dbus_rsp_error", 32'(dbus_rsp_error), 32'(rvd && mp_err));
    end

    if (reset) begin
      m_last_d = 1'b1;
      mp_valid = 1'b0;
    end else begin
      mp_valid = (ei || ed) && !ew;
      mp_src   = ed;
      mp_err   = !in_win(a);
      mp_data  = in_win(a) ? shadow[word_of(a)] : 32'h0;
      if (ok && ew)
        for (int b = 0; b < 4; b++)
          if (dbus_cmd_mask[b]) shadow[word_of(a)][8*b +: 8] = dbus_cmd_data[8*b +: 8];
      if (ei || ed) m_last_d = ed;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ibus_cmd_valid = 1'b0;
    dbus_cmd_valid = 1'b0;
    dbus_cmd_wr    = 1'b0;
    dbus_cmd_mask  = 4'h0;
  endtask

  task automatic drv_i(input logic [31:0] a);
    ibus_cmd_valid = 1'b1;
    ibus_cmd_addr  = a;
  endtask

  task automatic drv_d(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    dbus_cmd_valid = 1'b1;
    dbus_cmd_wr    = wr;
    dbus_cmd_addr  = a;
    dbus_cmd_data  = d;
    dbus_cmd_mask  = m;
  endtask

  initial begin
    logic [3:0] glog;
    int cnt;
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = 32'h1000_0000 + 32'(i);
      shadow[i] = 32'h1000_0000 + 32'(i);
    end
    mem[4] = 32'hDEAD_BEEF;    shadow[4] = 32'hDEAD_BEEF;
    mem[2] = 32'hAABB_CCDD;    shadow[2] = 32'hAABB_CCDD;
    ram_rdata = 32'h0;
    idle();
    ibus_cmd_addr = 32'h8000_0000;
    dbus_cmd_addr = 32'h8000_0004;
    dbus_cmd_data = 32'h0;
    reset = 1'b1;
    drv_i(32'h8000_0000);
    drv_d(1'b0, 32'h8000_0004, 32'h0, 4'h0);

    // Reset held with both buses requesting: nothing accepted.
    repeat (3) begin
      cyc(); #1;
      check("reset_quiet", {29'h0, ibus_cmd_ready, dbus_cmd_ready, ram_en}, 32'h0);
    end

    // Single fetch.
    cyc(); reset = 1'b0; idle(); drv_i(32'h8000_0010); #1;
    check("fetch_ram_addr", 32'(ram_addr), 32'h4);
    cyc(); idle(); #1;
    check("fetch_rsp_valid", 32'(ibus_rsp_valid), 32'h1);
    check("fetch_rsp_data", ibus_rsp_data, 32'hDEAD_BEEF);

    // Masked write, read back the merged word.
    cyc(); drv_d(1'b1, 32'h8000_0008, 32'h1122_3344, 4'b0101); #1;
    check("wr_ram_we", 32'(ram_we), 32'h5);
    cyc(); drv_d(1'b0, 32'h8000_0008, 32'h0, 4'h0); #1;
    check("wr_no_rsp", 32'(dbus_rsp_valid), 32'h0);
    cyc(); idle(); #1;
    check("rd_merged", dbus_rsp_data, 32'hAA22_CC44);

    // Zero-mask write strobes the RAM without writing and returns nothing.
    cyc(); drv_d(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000); #1;
    check("mask0_en_we", {27'h0, ram_en, ram_we}, 32'h10);
    cyc(); idle(); #1;
    check("mask0_no_rsp", 32'(dbus_rsp_valid), 32'h0);

    // Contention for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      cyc(); drv_i(32'h8000_0000); drv_d(1'b0, 32'h8000_0004, 32'h0, 4'h0); #1;
      glog[i] = dbus_cmd_ready;
    end
`ifdef VEX_ARB_DBUS_PRIORITY_EN
    check("contention_order", 32'(glog), 32'hF);
`else
    check("contention_order", 32'(glog), 32'hA);
`endif
    cyc(); idle();

    // Out of range below the window, then a write just past its top.
    cyc(); drv_i(32'h7FFF_FFFC); #1;
    check("oor_rd_no_en", 32'(ram_en), 32'h0);
    cyc(); idle(); drv_d(1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF); #1;
    check("oor_rsp_error", {ibus_rsp_error, ibus_rsp_data[30:0]}, 32'h8000_0000);
    check("oor_wr_no_en", 32'(ram_en), 32'h0);
    cyc(); drv_d(1'b0, 32'h8000_3FFC, 32'h0, 4'h0); #1;
    check("top_word_addr", 32'(ram_addr), 32'hFFF);
    cyc(); drv_d(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    cyc(); idle(); #1;
    check("word0_untouched", dbus_rsp_data, 32'h1000_0000);

    // Reset arriving right after an accepted read.
    cyc(); drv_d(1'b0, 32'h8000_0040, 32'h0, 4'h0);
    cyc(); idle(); reset = 1'b1; #1;
    check("rst_drops_rsp", 32'(dbus_rsp_valid), 32'h0);
    cyc(); reset = 1'b0; drv_i(32'h8000_0044); drv_d(1'b0, 32'h8000_0048, 32'h0, 4'h0); #1;
`ifdef VEX_ARB_DBUS_PRIORITY_EN
    check("post_rst_first", {30'h0, ibus_cmd_ready, dbus_cmd_ready}, 32'h1);
    cyc(); dbus_cmd_valid = 1'b0; #1;
    check("post_rst_loser", 32'(ibus_cmd_ready), 32'h1);
`else
    check("post_rst_first", {30'h0, ibus_cmd_ready, dbus_cmd_ready}, 32'h2);
    cyc(); ibus_cmd_valid = 1'b0; #1;
    check("post_rst_loser", 32'(dbus_cmd_ready), 32'h1);
`endif

    // 16 back-to-back fetches.
    cnt = 0;
    for (int i = 0; i <= 16; i++) begin
      cyc(); idle();
      if (i < 16) drv_i(32'h8000_0100 + 32'(4*i));
      #1;
      if (i > 0 && ibus_rsp_valid) cnt++;
    end
    check("burst_rsp_count", 32'(cnt), 32'd16);

    cyc(); idle();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
